// File: rtl/alu_result_bcd_driver.sv
// rtl/alu_result_bcd_driver.sv - iterative double-dabble BCD converter driving 7-segment digit LUTs
// One binary bit is consumed per clock; results are loaded into the output registers only on completion.
module alu_result_bcd_driver #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter bit LZB    = 1'b1
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iSTART,
  input  logic                  iSIGNED,
  input  logic [WIDTH-1:0]      iVALUE,
  output logic [4*DIGITS-1:0]   oBCD,
  output logic [DIGITS-1:0]     oON,
  output logic                  oNEG,
  output logic                  oBUSY,
  output logic                  oDONE
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] ON_RST = LZB ? DIGITS'(1) : {DIGITS{1'b1}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [BW-1:0]    bcd_w;
  logic [WIDTH-1:0] bin_w;
  logic [CW-1:0]    cnt;
  logic             neg_w;

  logic [BW-1:0]    bcd_adj;
  logic [BW-1:0]    bcd_nxt;
  logic [WIDTH-1:0] bin_nxt;
  logic [DIGITS-1:0] on_nxt;
  logic             any_nz;
  logic             is_neg;
  logic [WIDTH-1:0] mag;

  assign is_neg = iSIGNED & iVALUE[WIDTH-1];
  assign mag    = is_neg ? (~iVALUE + WIDTH'(1)) : iVALUE;

  // Add-3 is applied per nibble so no carry can cross into the next digit.
  always_comb begin
    bcd_adj = bcd_w;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_w[4*k +: 4] >= 4'd5)
        bcd_adj[4*k +: 4] = bcd_w[4*k +: 4] + 4'd3;
    end
    {bcd_nxt, bin_nxt} = {bcd_adj, bin_w} << 1;
  end

  // A digit lights when it or any more-significant digit is nonzero.
  always_comb begin
    any_nz = 1'b0;
    on_nxt = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      any_nz    = any_nz | (|bcd_nxt[4*k +: 4]);
      on_nxt[k] = any_nz;
    end
    on_nxt[0] = 1'b1;
    if (!LZB)
      on_nxt = {DIGITS{1'b1}};
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
      bcd_w <= '0;
      bin_w <= '0;
      cnt   <= '0;
      neg_w <= 1'b0;
      oBCD  <= '0;
      oON   <= ON_RST;
      oNEG  <= 1'b0;
      oBUSY <= 1'b0;
      oDONE <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iSTART) begin
            bin_w <= mag;
            neg_w <= is_neg;
            bcd_w <= '0;
            cnt   <= '0;
            oBUSY <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_w <= bcd_nxt;
          bin_w <= bin_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            oBCD  <= bcd_nxt;
            oON   <= on_nxt;
            oNEG  <= neg_w;
            oDONE <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          oDONE <= 1'b0;
          oBUSY <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_bcd_driver.sv
// tb/tb_alu_result_bcd_driver.sv - directed checks of the BCD driver with and without leading-zero blanking
module tb_alu_result_bcd_driver;

  logic        iCLK;
  logic        iRST;
  logic        iSTART;
  logic        iSIGNED;
  logic [15:0] iVALUE;
  logic [19:0] oBCD,  nb_bcd;
  logic [4:0]  oON,   nb_on;
  logic        oNEG,  nb_neg;
  logic        oBUSY, nb_busy;
  logic        oDONE, nb_done;

  int checks = 0;
  int errors = 0;
  int lat;
  int busy_n;
  int seen_done;

  alu_result_bcd_driver #(.WIDTH(16), .DIGITS(5), .LZB(1'b1)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iSIGNED(iSIGNED), .iVALUE(iVALUE),
    .oBCD(oBCD), .oON(oON), .oNEG(oNEG), .oBUSY(oBUSY), .oDONE(oDONE)
  );

  alu_result_bcd_driver #(.WIDTH(16), .DIGITS(5), .LZB(1'b0)) dut_nb (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iSIGNED(iSIGNED), .iVALUE(iVALUE),
    .oBCD(nb_bcd), .oON(nb_on), .oNEG(nb_neg), .oBUSY(nb_busy), .oDONE(nb_done)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a conversion and returns in the cycle where oDONE is expected.
  task automatic conv(input logic [15:0] v, input logic s, output int l, output int b);
    iVALUE  = v;
    iSIGNED = s;
    iSTART  = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    l = 0;
    b = 0;
    while (!oDONE && l < 40) begin
      b += int'(oBUSY);
      @(posedge iCLK); #1;
      l++;
    end
    b += int'(oBUSY);
    check("latency", l, 16);
  endtask

  task automatic post_done(input int b);
    check("busy_cycles", b, 17);
    @(posedge iCLK); #1;
    check("done_pulse_end", oDONE, 1'b0);
    check("busy_end", oBUSY, 1'b0);
  endtask

  initial begin
    iRST = 1'b1; iSTART = 1'b0; iSIGNED = 1'b0; iVALUE = '0;
    repeat (2) @(posedge iCLK);
    #1;
    check("rst_bcd", oBCD, 20'h0);
    check("rst_on", oON, 5'b00001);
    check("rst_on_nb", nb_on, 5'b11111);
    check("rst_neg", oNEG, 1'b0);
    check("rst_busy", oBUSY, 1'b0);
    check("rst_done", oDONE, 1'b0);
    iRST = 1'b0;
    @(posedge iCLK); #1;

    conv(16'hFFFF, 1'b0, lat, busy_n);
    check("umax_bcd", oBCD, 20'h65535);
    check("umax_on", oON, 5'b11111);
    check("umax_neg", oNEG, 1'b0);
    post_done(busy_n);

    conv(16'h8000, 1'b1, lat, busy_n);
    check("smin_bcd", oBCD, 20'h32768);
    check("smin_neg", oNEG, 1'b1);
    check("smin_on", oON, 5'b11111);
    post_done(busy_n);

    conv(16'hFFFF, 1'b1, lat, busy_n);
    check("sm1_bcd", oBCD, 20'h00001);
    check("sm1_neg", oNEG, 1'b1);
    check("sm1_on", oON, 5'b00001);
    post_done(busy_n);

    conv(16'h0000, 1'b0, lat, busy_n);
    check("zero_bcd", oBCD, 20'h0);
    check("zero_on", oON, 5'b00001);
    check("zero_on_nb", nb_on, 5'b11111);
    check("zero_neg", oNEG, 1'b0);
    post_done(busy_n);

    conv(16'h00FF, 1'b0, lat, busy_n);
    check("ff_bcd", oBCD, 20'h00255);
    check("ff_on", oON, 5'b00111);
    check("ff_on_nb", nb_on, 5'b11111);
    check("ff_bcd_nb", nb_bcd, 20'h00255);
    post_done(busy_n);

    // Second start at edge 5 must be ignored; outputs hold the prior result meanwhile.
    iVALUE = 16'd1234; iSIGNED = 1'b0; iSTART = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    repeat (4) @(posedge iCLK);
    #1;
    check("hold_bcd", oBCD, 20'h00255);
    check("hold_on", oON, 5'b00111);
    check("mid_busy", oBUSY, 1'b1);
    iVALUE = 16'd9; iSTART = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    lat = 5;
    while (!oDONE && lat < 40) begin
      @(posedge iCLK); #1;
      lat++;
    end
    check("ignore_latency", lat, 16);
    check("ignore_bcd", oBCD, 20'h01234);
    check("ignore_on", oON, 5'b01111);
    @(posedge iCLK); #1;
    check("ignore_done_end", oDONE, 1'b0);

    conv(16'd9, 1'b0, lat, busy_n);
    check("after_done_bcd", oBCD, 20'h00009);
    check("after_done_on", oON, 5'b00001);
    post_done(busy_n);

    iVALUE = 16'd4321; iSIGNED = 1'b0; iSTART = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    repeat (7) @(posedge iCLK);
    #1;
    iRST = 1'b1;
    @(posedge iCLK); #1;
    check("abort_bcd", oBCD, 20'h0);
    check("abort_on", oON, 5'b00001);
    check("abort_neg", oNEG, 1'b0);
    check("abort_busy", oBUSY, 1'b0);
    check("abort_done", oDONE, 1'b0);
    iRST = 1'b0;
    seen_done = 0;
    repeat (30) begin
      @(posedge iCLK); #1;
      if (oDONE) seen_done = 1;
    end
    check("abort_no_done", seen_done, 0);

    conv(16'd4321, 1'b0, lat, busy_n);
    check("fresh_bcd", oBCD, 20'h04321);
    check("fresh_on", oON, 5'b01111);
    post_done(busy_n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
